// File: rtl/waveform_loader_if.sv
// Host byte-stream link (valid/ready) carrying waveform table frames.
interface waveform_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/waveform_loader.sv
// Waveform table writer: parses framed byte stream into 32-bit phase words,
// writes them at {mode, phase}, and keeps per-mode phase counts and valid flags.
module waveform_loader #(
  parameter logic [7:0] MAGIC = 8'hEB
) (
  input  logic                clk,
  input  logic                reset_n,
  waveform_loader_if.slave    s,
  input  logic                abort,
  output logic                wr_en,
  output logic [8:0]          wr_addr,
  output logic [31:0]         wr_data,
  input  logic [1:0]          count_sel,
  output logic [6:0]          count_out,
  output logic [3:0]          mode_valid,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code
);

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned PHASE_W   = 7;
  localparam int unsigned NUM_MODES = 1 << MODE_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MODE  = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;

  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_COUNT = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  logic [2:0]         state, state_nxt;
  logic [MODE_W-1:0]  mode_q, mode_nxt;
  logic [PHASE_W-1:0] count_q, count_nxt;
  logic [PHASE_W-1:0] phase_idx, phase_nxt;
  logic [1:0]         byte_idx, byte_nxt;
  logic [31:0]        word_q, word_nxt;
  logic [7:0]         sum_q, sum_nxt;
  logic [PHASE_W-1:0] count_tbl     [NUM_MODES];
  logic [PHASE_W-1:0] count_tbl_nxt [NUM_MODES];
  logic [3:0]         mode_valid_nxt;
  logic               done_nxt, error_nxt;
  logic [1:0]         err_code_nxt;
  logic               accept;

  assign accept    = s.s_valid && s.s_ready;
  // Write strobe stays combinational so an abort in WRITE can still cancel it.
  assign wr_en     = (state == ST_WRITE) && !abort;
  assign wr_addr   = {mode_q, phase_idx};
  assign wr_data   = word_q;
  assign count_out = count_tbl[count_sel];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      count_q    <= '0;
      phase_idx  <= '0;
      byte_idx   <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      for (int i = 0; i < int'(NUM_MODES); i++) count_tbl[i] <= '0;
      mode_valid <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
      s.s_ready  <= 1'b1;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      count_q    <= count_nxt;
      phase_idx  <= phase_nxt;
      byte_idx   <= byte_nxt;
      word_q     <= word_nxt;
      sum_q      <= sum_nxt;
      count_tbl  <= count_tbl_nxt;
      mode_valid <= mode_valid_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      err_code   <= err_code_nxt;
      busy       <= (state_nxt != ST_IDLE);
      s.s_ready  <= (state_nxt != ST_WRITE);
    end
  end

  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode_q;
    count_nxt      = count_q;
    phase_nxt      = phase_idx;
    byte_nxt       = byte_idx;
    word_nxt       = word_q;
    sum_nxt        = sum_q;
    count_tbl_nxt  = count_tbl;
    mode_valid_nxt = mode_valid;
    done_nxt       = 1'b0;
    error_nxt      = 1'b0;
    err_code_nxt   = err_code;

    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          if (s.s_data == MAGIC) begin
            state_nxt = ST_MODE;
          end else begin
            error_nxt    = 1'b1;
            err_code_nxt = ERR_MAGIC;
          end
        end
        // Slot is invalidated as soon as a reload targets it.
        ST_MODE: if (accept) begin
          mode_nxt                 = s.s_data[MODE_W-1:0];
          mode_valid_nxt[mode_nxt] = 1'b0;
          sum_nxt                  = s.s_data;
          state_nxt                = ST_COUNT;
        end
        ST_COUNT: if (accept) begin
          sum_nxt = sum_q + s.s_data;
          if (s.s_data == 8'h00 || s.s_data[7]) begin
            error_nxt    = 1'b1;
            err_code_nxt = ERR_COUNT;
            state_nxt    = ST_IDLE;
          end else begin
            count_nxt = s.s_data[PHASE_W-1:0];
            phase_nxt = '0;
            byte_nxt  = '0;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: if (accept) begin
          word_nxt[{byte_idx, 3'b000} +: 8] = s.s_data;
          sum_nxt  = sum_q + s.s_data;
          byte_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_nxt = ST_WRITE;
        end
        ST_WRITE: begin
          phase_nxt = phase_idx + 7'd1;
          state_nxt = (phase_idx == count_q - 7'd1) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: if (accept) begin
          if (s.s_data == sum_q) begin
            count_tbl_nxt[mode_q]  = count_q;
            mode_valid_nxt[mode_q] = 1'b1;
            done_nxt               = 1'b1;
          end else begin
            error_nxt    = 1'b1;
            err_code_nxt = ERR_CSUM;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_loader.sv
// Directed self-checking bench for waveform_loader.
module tb_waveform_loader;

  logic        clk;
  logic        reset_n;
  logic        abort;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  count_sel;
  logic [6:0]  count_out;
  logic [3:0]  mode_valid;
  logic        busy, done, error;
  logic [1:0]  err_code;

  waveform_loader_if bus();

  waveform_loader dut (
    .clk(clk), .reset_n(reset_n), .s(bus), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .count_sel(count_sel), .count_out(count_out), .mode_valid(mode_valid),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int done_cnt, err_cnt, low_cnt, low_run, max_run;
  logic [1:0] last_code;
  logic [7:0] txq[$];

  // Observe DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin wq_addr.push_back(wr_addr); wq_data.push_back(wr_data); end
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) begin err_cnt++; last_code = err_code; end
    if (bus.s_ready === 1'b0) begin
      low_cnt++; low_run++;
      if (low_run > max_run) max_run = low_run;
    end else low_run = 0;
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete();
    done_cnt = 0; err_cnt = 0; low_cnt = 0; low_run = 0; max_run = 0; last_code = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit ok;
    ok = 0; waits = 0;
    bus.s_data = b; bus.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin @(posedge clk); #1; ok = 1; break; end
      waits++;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_byte timeout byte=%02h s_ready stayed low, required accept within 16 cycles", b);
    end
  endtask

  task automatic send_txq(output int first_wait, output int total_wait);
    int w;
    total_wait = 0; first_wait = 0;
    foreach (txq[i]) begin
      send_byte(txq[i], w);
      if (i == 0) first_wait = w;
      total_wait += w;
    end
    txq.delete();
  endtask

  task automatic go_idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_frame1(input logic [7:0] csum);
    int fw, tw;
    txq = '{8'hEB, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    txq.push_back(csum);
    send_txq(fw, tw);
    go_idle(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; abort = 1'b0; count_sel = 2'd0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00;
    repeat (2) @(negedge clk);
    vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {busy, done, error}); end
    vectors++; if (err_code !== 2'b00) begin miscompares++; $display("FAIL reset_err_code got %b want 00", err_code); end
    vectors++; if (mode_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_mode_valid got %b want 0000", mode_valid); end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      count_sel = 2'(m); #1;
      vectors++; if (count_out !== 7'd0) begin miscompares++; $display("FAIL reset_count sel=%0d got %0d want 0", m, count_out); end
    end
    go_idle(2);
  endtask

  // Sum 01+02+11+..+88 = 0x267, so the good checksum byte is 0x67.
  task automatic test_good_frame();
    clear_mon();
    load_frame1(8'h67);
    vectors++; if (wq_addr.size() !== 2) begin miscompares++; $display("FAIL good_nwrites got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      vectors++; if (wq_addr[0] !== 9'h080 || wq_data[0] !== 32'h44332211) begin miscompares++; $display("FAIL good_w0 got %h:%h want 080:44332211", wq_addr[0], wq_data[0]); end
      vectors++; if (wq_addr[1] !== 9'h081 || wq_data[1] !== 32'h88776655) begin miscompares++; $display("FAIL good_w1 got %h:%h want 081:88776655", wq_addr[1], wq_data[1]); end
    end
    vectors++; if (done_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL good_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    vectors++; if (mode_valid !== 4'b0010) begin miscompares++; $display("FAIL good_mode_valid got %b want 0010", mode_valid); end
    count_sel = 2'd1; #1;
    vectors++; if (count_out !== 7'd2) begin miscompares++; $display("FAIL good_count got %0d want 2", count_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL good_busy got %b want 0", busy); end
  endtask

  task automatic test_bad_csum();
    clear_mon();
    load_frame1(8'h64);
    vectors++; if (wq_addr.size() !== 2) begin miscompares++; $display("FAIL csum_nwrites got %0d want 2", wq_addr.size()); end
    vectors++; if (err_cnt !== 1 || last_code !== 2'b11 || done_cnt !== 0) begin miscompares++; $display("FAIL csum_error got err=%0d code=%b done=%0d want 1/11/0", err_cnt, last_code, done_cnt); end
    vectors++; if (mode_valid !== 4'b0000) begin miscompares++; $display("FAIL csum_mode_valid got %b want 0000", mode_valid); end
    count_sel = 2'd1; #1;
    vectors++; if (count_out !== 7'd2) begin miscompares++; $display("FAIL csum_count got %0d want 2", count_out); end
  endtask

  task automatic test_stray_byte();
    int w;
    clear_mon();
    send_byte(8'h00, w);
    go_idle(2);
    vectors++; if (err_cnt !== 1 || last_code !== 2'b01) begin miscompares++; $display("FAIL stray_error got err=%0d code=%b want 1/01", err_cnt, last_code); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stray_busy got %b want 0", busy); end
    load_frame1(8'h67);
    vectors++; if (done_cnt !== 1 || err_cnt !== 1) begin miscompares++; $display("FAIL stray_then_frame got done=%0d err=%0d want 1/1", done_cnt, err_cnt); end
    vectors++; if (mode_valid !== 4'b0010 || err_code !== 2'b01) begin miscompares++; $display("FAIL stray_state got mv=%b code=%b want 0010/01", mode_valid, err_code); end
  endtask

  task automatic test_bad_count();
    int fw, tw;
    clear_mon();
    txq = '{8'hEB, 8'h02, 8'h00};
    send_txq(fw, tw); go_idle(2);
    vectors++; if (err_cnt !== 1 || last_code !== 2'b10) begin miscompares++; $display("FAIL count0 got err=%0d code=%b want 1/10", err_cnt, last_code); end
    txq = '{8'hEB, 8'h02, 8'h80};
    send_txq(fw, tw); go_idle(2);
    vectors++; if (err_cnt !== 2 || last_code !== 2'b10) begin miscompares++; $display("FAIL count128 got err=%0d code=%b want 2/10", err_cnt, last_code); end
    vectors++; if (wq_addr.size() !== 0) begin miscompares++; $display("FAIL count_nowrite got %0d want 0", wq_addr.size()); end
    vectors++; if (mode_valid !== 4'b0010 || busy !== 1'b0) begin miscompares++; $display("FAIL count_state got mv=%b busy=%b want 0010/0", mode_valid, busy); end
  endtask

  task automatic test_long_frame();
    int fw, tw, bad;
    logic [7:0] sum, b;
    logic [31:0] exp_w;
    clear_mon();
    sum = 8'h03 + 8'h7F;
    txq = '{8'hEB, 8'h03, 8'h7F};
    for (int k = 0; k < 508; k++) begin
      b = 8'(k); txq.push_back(b); sum = sum + b;
    end
    txq.push_back(sum);
    send_txq(fw, tw);
    go_idle(3);
    vectors++; if (wq_addr.size() !== 127) begin miscompares++; $display("FAIL long_nwrites got %0d want 127", wq_addr.size()); end
    bad = 0;
    if (wq_addr.size() == 127) begin
      for (int i = 0; i < 127; i++) begin
        exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        if (wq_addr[i] !== 9'(9'h180 + i) || wq_data[i] !== exp_w) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL long_words got %0d wrong words want 0", bad); end
    end
    vectors++; if (low_cnt !== 127 || max_run !== 1) begin miscompares++; $display("FAIL long_ready got low=%0d run=%0d want 127/1", low_cnt, max_run); end
    vectors++; if (tw !== 127) begin miscompares++; $display("FAIL long_stalls got %0d want 127", tw); end
    vectors++; if (done_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL long_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    count_sel = 2'd3; #1;
    vectors++; if (count_out !== 7'd127 || mode_valid !== 4'b1010) begin miscompares++; $display("FAIL long_count got cnt=%0d mv=%b want 127/1010", count_out, mode_valid); end
  endtask

  // Frame sums: 00+01+01+02+03+04 = 0x0B; 02+01+AA+BB+CC+DD = 0x311 -> 0x11.
  task automatic test_back_to_back();
    int fw, tw;
    clear_mon();
    txq = '{8'hEB, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send_txq(fw, tw);
    txq = '{8'hEB, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    send_txq(fw, tw);
    go_idle(3);
    vectors++; if (fw !== 0) begin miscompares++; $display("FAIL b2b_magic_wait got %0d want 0", fw); end
    vectors++; if (done_cnt !== 2 || err_cnt !== 0) begin miscompares++; $display("FAIL b2b_done got done=%0d err=%0d want 2/0", done_cnt, err_cnt); end
    vectors++; if (wq_addr.size() !== 2) begin miscompares++; $display("FAIL b2b_nwrites got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      vectors++; if (wq_addr[0] !== 9'h000 || wq_data[0] !== 32'h04030201) begin miscompares++; $display("FAIL b2b_w0 got %h:%h want 000:04030201", wq_addr[0], wq_data[0]); end
      vectors++; if (wq_addr[1] !== 9'h100 || wq_data[1] !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL b2b_w1 got %h:%h want 100:ddccbbaa", wq_addr[1], wq_data[1]); end
    end
    vectors++; if (mode_valid !== 4'b1111) begin miscompares++; $display("FAIL b2b_mode_valid got %b want 1111", mode_valid); end
  endtask

  task automatic test_abort_reset();
    int fw, tw;
    clear_mon();
    txq = '{8'hEB, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33};
    send_txq(fw, tw);
    // Abort coincides with the 4th data byte; abort must win.
    bus.s_data = 8'h44; bus.s_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    go_idle(3);
    vectors++; if (wq_addr.size() !== 0 || done_cnt !== 0 || err_cnt !== 0) begin miscompares++; $display("FAIL abort_quiet got wr=%0d done=%0d err=%0d want 0/0/0", wq_addr.size(), done_cnt, err_cnt); end
    vectors++; if (mode_valid !== 4'b1101 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_state got mv=%b busy=%b want 1101/0", mode_valid, busy); end
    txq = '{8'hEB, 8'h03, 8'h01, 8'h11, 8'h22};
    send_txq(fw, tw);
    bus.s_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    vectors++; if (mode_valid !== 4'b0000 || bus.s_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid got mv=%b rdy=%b busy=%b want 0000/1/0", mode_valid, bus.s_ready, busy); end
    vectors++; if (err_code !== 2'b00 || {done, error, wr_en} !== 3'b000) begin miscompares++; $display("FAIL rst_mid_outs got code=%b dew=%b want 00/000", err_code, {done, error, wr_en}); end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      count_sel = 2'(m); #1;
      vectors++; if (count_out !== 7'd0) begin miscompares++; $display("FAIL rst_count sel=%0d got %0d want 0", m, count_out); end
    end
    vectors++; if (wq_addr.size() !== 0 || done_cnt !== 0 || err_cnt !== 0) begin miscompares++; $display("FAIL rst_quiet got wr=%0d done=%0d err=%0d want 0/0/0", wq_addr.size(), done_cnt, err_cnt); end
    go_idle(1);
    clear_mon();
    load_frame1(8'h67);
    vectors++; if (done_cnt !== 1 || wq_addr.size() !== 2 || mode_valid !== 4'b0010) begin miscompares++; $display("FAIL rst_reload got done=%0d wr=%0d mv=%b want 1/2/0010", done_cnt, wq_addr.size(), mode_valid); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_stray_byte();
    test_bad_count();
    test_long_frame();
    test_back_to_back();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
